// File: rtl/cnn_accel_responder.sv
// cnn_accel_responder
// Services accelerator instructions sitting in the EX slot. The front of the
// pipeline is frozen while a command is handed to the CNN core over a req/ack
// handshake. The bench returns the CNN result (or an all-ones value after a
// timeout) as a single-cycle writeback into the EX/MEM register.

module cnn_accel_responder #(
  parameter int TIMEOUT = 1024,
  parameter int TMO_W   = 11
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        id_ex_is_accel,
  input  logic [31:0] id_ex_instr,
  input  logic [31:0] id_ex_rs1,
  input  logic [31:0] id_ex_rs2,
  input  logic [4:0]  id_ex_rd,
  input  logic        id_ex_rd_valid,
  output logic        stall,
  output logic        cnn_req,
  input  logic        cnn_ack,
  output logic [2:0]  cnn_op,
  output logic [31:0] cnn_arg0,
  output logic [31:0] cnn_arg1,
  input  logic        cnn_done,
  input  logic [31:0] cnn_result,
  output logic [31:0] ex_val,
  output logic [4:0]  ex_rd,
  output logic        ex_valid,
  output logic        ex_is_cnn,
  output logic        timeout_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_t;

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  state_t           state;
  logic [TMO_W-1:0] tmo_cnt;
  logic [4:0]       rd_q;
  logic             rd_valid_q;

  // The instruction is held in ID/EX while it is outstanding. RESP releases it.
  assign stall = ((state == IDLE) && id_ex_is_accel) ||
                 (state == REQ) || (state == WAIT);

  // The sequencer and all registered outputs. The writeback fields are
  // loaded on the edge into RESP, so they are valid for exactly that cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      tmo_cnt     <= '0;
      rd_q        <= '0;
      rd_valid_q  <= 1'b0;
      cnn_req     <= 1'b0;
      cnn_op      <= '0;
      cnn_arg0    <= '0;
      cnn_arg1    <= '0;
      ex_val      <= '0;
      ex_rd       <= '0;
      ex_valid    <= 1'b0;
      ex_is_cnn   <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      ex_val    <= '0;
      ex_rd     <= '0;
      ex_valid  <= 1'b0;
      ex_is_cnn <= 1'b0;

      case (state)
        IDLE: begin
          if (id_ex_is_accel) begin
            cnn_op     <= id_ex_instr[14:12];
            cnn_arg0   <= id_ex_rs1;
            cnn_arg1   <= id_ex_rs2;
            rd_q       <= id_ex_rd;
            rd_valid_q <= id_ex_rd_valid;
            cnn_req    <= 1'b1;
            tmo_cnt    <= '0;
            state      <= REQ;
          end
        end

        REQ: begin
          tmo_cnt <= tmo_cnt + 1'b1;
          if (cnn_ack) begin
            cnn_req <= 1'b0;
            if (cnn_done) begin
              ex_val    <= cnn_result;
              ex_rd     <= rd_valid_q ? rd_q : 5'd0;
              ex_valid  <= 1'b1;
              ex_is_cnn <= 1'b1;
              state     <= RESP;
            end else begin
              state <= WAIT;
            end
          end else if (tmo_cnt == TMO_LAST) begin
            cnn_req     <= 1'b0;
            timeout_err <= 1'b1;
            ex_val      <= 32'hFFFF_FFFF;
            ex_rd       <= rd_valid_q ? rd_q : 5'd0;
            ex_valid    <= 1'b1;
            ex_is_cnn   <= 1'b1;
            state       <= RESP;
          end
        end

        WAIT: begin
          tmo_cnt <= tmo_cnt + 1'b1;
          if (cnn_done) begin
            ex_val    <= cnn_result;
            ex_rd     <= rd_valid_q ? rd_q : 5'd0;
            ex_valid  <= 1'b1;
            ex_is_cnn <= 1'b1;
            state     <= RESP;
          end else if (tmo_cnt == TMO_LAST) begin
            timeout_err <= 1'b1;
            ex_val      <= 32'hFFFF_FFFF;
            ex_rd       <= rd_valid_q ? rd_q : 5'd0;
            ex_valid    <= 1'b1;
            ex_is_cnn   <= 1'b1;
            state       <= RESP;
          end
        end

        RESP: begin
          state <= IDLE;
        end

        default: begin
          state   <= IDLE;
          cnn_req <= 1'b0;
        end
      endcase
    end
  end

endmodule
